// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the rx pin, recovers bytes with mid-bit sampling
// and offers them on a valid/ready stream, flagging framing errors and overruns.
module uart_rx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200,
  parameter int SYNC   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);

  // state  | meaning
  // IDLE   | line idle, waiting for a falling edge
  // START  | timing to the middle of the start bit to reject glitches
  // DATA   | sampling eight data bits, LSB first, at bit centres
  // STOP   | sampling the stop bit
  // BREAK  | stop bit was low; wait for the line to return high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_nxt;
  logic [SYNC-1:0] sync_q;
  logic          rs;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    rx_byte, rx_byte_nxt;
  logic          done, done_nxt;
  logic          ferr_nxt;

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], rx};
    end
  end

  assign rs = sync_q[SYNC-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      rx_byte   <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      rx_byte   <= rx_byte_nxt;
      done      <= done_nxt;
      frame_err <= ferr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CW'(1);
    idx_nxt     = idx;
    rx_byte_nxt = rx_byte;
    done_nxt    = 1'b0;
    ferr_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (!rs) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt = '0;
          if (!rs) begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt          = '0;
          rx_byte_nxt[idx] = rs;
          if (idx == 3'd7) state_nxt = S_STOP;
          else             idx_nxt   = idx + 3'd1;
        end
      end
      S_STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_nxt = '0;
          if (rs) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_nxt = '0;
        if (rs) state_nxt = S_IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // A completed byte is only taken if the output slot is free or being drained this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data  <= rx_byte;
          valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial line driver pushes expected bytes,
// a negedge monitor pops and compares them on every valid&&ready handshake.
module tb_uart_rx;
  localparam int CPB  = 434;
  localparam int HALF = 217;

  logic       clk = 1'b0;
  logic       rst, rx, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  always #10 clk = ~clk;

  uart_rx #(.CLK_HZ(50_000_000), .BAUD(115_200), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ready(ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, vhi_cnt = 0, rise_cnt = 0, busy_cnt = 0, hs_cnt = 0;
  int last_rise = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: pulse/level counters plus scoreboard pop on each accepted byte.
  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1) ov_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (valid === 1'b1) vhi_cnt++;
    if (valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cnt++;
      last_rise = cyc;
    end
    prev_valid = valid;
    if (valid === 1'b1 && ready === 1'b1) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got %0h expected none", data);
      end else begin
        check("data", int'(data), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    idle(n);
  endtask

  task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_v);
    drive_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bc);
    drive_bit(stop_v, bc);
  endtask

  int st, r0, exp_hs;
  logic [7:0] rb;

  initial begin
    exp_hs = 0;
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    idle(5);
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    idle(10);

    // Single byte, consumer always ready: latency and one-cycle valid.
    ready = 1'b1;
    vhi_cnt = 0; fe_cnt = 0; ov_cnt = 0;
    @(posedge clk); #1;
    st = cyc;
    exp_q.push_back(8'h55); exp_hs++;
    send_byte(8'h55, CPB, 1'b1);
    idle(CPB);
    check_range("latency_55", last_rise - st, 4124, 4128);
    check("valid_cycles_55", vhi_cnt, 1);
    check("fe_55", fe_cnt, 0);
    check("ov_55", ov_cnt, 0);

    // Back-to-back with stalled consumer: second byte overruns.
    ready = 1'b0;
    r0 = rise_cnt; ov_cnt = 0;
    exp_q.push_back(8'hA3); exp_hs++;
    send_byte(8'hA3, CPB, 1'b1);
    send_byte(8'h0F, CPB, 1'b1);
    idle(CPB);
    check("hold_valid", int'(valid), 1);
    check("hold_data", int'(data), 8'hA3);
    check("overrun_pulses", ov_cnt, 1);
    check("valid_rises_b2b", rise_cnt - r0, 1);
    ready = 1'b1;
    idle(3);
    check("valid_after_accept", int'(valid), 0);

    // Framing error, long break, then clean byte.
    r0 = rise_cnt; fe_cnt = 0;
    send_byte(8'h81, CPB, 1'b0);
    drive_bit(1'b0, 20 * CPB);
    drive_bit(1'b1, CPB);
    check("frame_err_pulses", fe_cnt, 1);
    check("no_valid_81", rise_cnt - r0, 0);
    exp_q.push_back(8'h42); exp_hs++;
    send_byte(8'h42, CPB, 1'b1);
    idle(CPB);
    check("fe_after_42", fe_cnt, 1);
    check("rises_42", rise_cnt - r0, 1);

    // Short glitch in idle is rejected at mid start bit.
    r0 = rise_cnt; busy_cnt = 0;
    drive_bit(1'b0, 100);
    drive_bit(1'b1, 400);
    check_range("glitch_busy_cycles", busy_cnt, HALF - 2, HALF + 2);
    check("glitch_busy_end", int'(busy), 0);
    check("glitch_no_valid", rise_cnt - r0, 0);

    // Reset mid-frame aborts the byte.
    r0 = rise_cnt;
    fork
      send_byte(8'hFF, CPB, 1'b1);
      begin
        idle(4 * CPB);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("abort_valid", int'(valid), 0);
        check("abort_data", int'(data), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_fe", int'(frame_err), 0);
        check("abort_ov", int'(overrun), 0);
      end
    join
    idle(CPB);
    check("abort_no_valid", rise_cnt - r0, 0);
    exp_q.push_back(8'h3C); exp_hs++;
    send_byte(8'h3C, CPB, 1'b1);
    idle(CPB);

    // Baud skew of +-2%.
    fe_cnt = 0;
    exp_q.push_back(8'h96); exp_hs++;
    send_byte(8'h96, 443, 1'b1);
    idle(CPB);
    exp_q.push_back(8'h96); exp_hs++;
    send_byte(8'h96, 425, 1'b1);
    idle(CPB);
    check("skew_fe", fe_cnt, 0);

    // Random bytes, small rate jitter and random idle gaps.
    ov_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      rb = 8'($urandom);
      exp_q.push_back(rb); exp_hs++;
      send_byte(rb, CPB - 4 + int'($urandom_range(0, 8)), 1'b1);
      idle(int'($urandom_range(1, CPB)));
    end
    idle(CPB);
    check("rand_fe", fe_cnt, 0);
    check("rand_ov", ov_cnt, 0);
    check("queue_empty", exp_q.size(), 0);
    check("handshakes", hs_cnt, exp_hs);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
